// File: rtl/pipelined_modify_radix2_if.sv
// Sample/handshake bundle for the pipelined modified radix-2 butterfly.
// The master drives samples and out_ready; the slave is the butterfly itself.
interface pipelined_modify_radix2_if #(
    parameter int unsigned bit_width      = 16,
    parameter int unsigned word_length_tw = 8
);
    logic                             in_valid;
    logic                             in_ready;
    logic                             mode;
    logic                             scale;
    logic signed [word_length_tw-1:0] sin_data;
    logic signed [word_length_tw-1:0] cos_data;
    logic signed [word_length_tw-1:0] sin_data2;
    logic signed [word_length_tw-1:0] cos_data2;
    logic signed [bit_width-1:0]      Re_i1;
    logic signed [bit_width-1:0]      Im_i1;
    logic signed [bit_width-1:0]      Re_i2;
    logic signed [bit_width-1:0]      Im_i2;
    logic                             out_ready;
    logic signed [bit_width-1:0]      Re_o1;
    logic signed [bit_width-1:0]      Im_o1;
    logic signed [bit_width-1:0]      Re_o2;
    logic signed [bit_width-1:0]      Im_o2;
    logic                             out_valid;
    logic                             ovf;
    logic                             clr_ovf;

    modport master (
        output in_valid, mode, scale, sin_data, cos_data, sin_data2, cos_data2,
        output Re_i1, Im_i1, Re_i2, Im_i2, out_ready, clr_ovf,
        input  in_ready, Re_o1, Im_o1, Re_o2, Im_o2, out_valid, ovf
    );

    modport slave (
        input  in_valid, mode, scale, sin_data, cos_data, sin_data2, cos_data2,
        input  Re_i1, Im_i1, Re_i2, Im_i2, out_ready, clr_ovf,
        output in_ready, Re_o1, Im_o1, Re_o2, Im_o2, out_valid, ovf
    );
endinterface

// File: rtl/pipelined_modify_radix2.sv
// Four-stage modified radix-2 butterfly: one or two twiddle rotations of b, then saturating
// a +/- t with optional halving, rounding and a sticky overflow flag, under a global stall.
module pipelined_modify_radix2 #(
    parameter int unsigned bit_width      = 16,
    parameter int unsigned word_length_tw = 8,
    parameter bit          ROUND          = 1'b1
) (
    input logic                      clk,
    input logic                      rst,
    pipelined_modify_radix2_if.slave bus
);
    localparam int unsigned FW = bit_width + word_length_tw + 1;
    localparam int unsigned SH = word_length_tw - 2;

    typedef logic signed [bit_width-1:0]      word_t;
    typedef logic signed [word_length_tw-1:0] tw_t;
    typedef logic signed [FW-1:0]             full_t;
    typedef struct packed {word_t re; word_t im;} cplx_t;

    typedef struct packed {
        logic  mode;
        logic  scale;
        tw_t   cos1;
        tw_t   sin1;
        tw_t   cos2;
        tw_t   sin2;
        cplx_t a;
        cplx_t b;
    } s1_t;
    typedef struct packed {
        logic  mode;
        logic  scale;
        tw_t   cos2;
        tw_t   sin2;
        cplx_t a;
        cplx_t t;
    } s2_t;
    typedef struct packed {
        logic  scale;
        cplx_t a;
        cplx_t t;
    } s3_t;
    typedef struct packed {
        cplx_t o1;
        cplx_t o2;
    } s4_t;

    localparam full_t MaxF   = full_t'({{(FW-bit_width+1){1'b0}}, {(bit_width-1){1'b1}}});
    localparam full_t MinF   = full_t'({{(FW-bit_width+1){1'b1}}, {(bit_width-1){1'b0}}});
    localparam full_t OneF   = full_t'({{(FW-1){1'b0}}, 1'b1});
    localparam full_t HalfTw = full_t'({{(FW-1){1'b0}}, 1'b1} << (SH - 1));

    function automatic full_t rescale(input full_t acc, input int unsigned sh, input full_t half);
        full_t r;
        r = acc;
        if (ROUND) r = acc + half;
        return r >>> sh;
    endfunction

    function automatic logic clips(input full_t x);
        return (x > MaxF) || (x < MinF);
    endfunction

    function automatic word_t clamp(input full_t x);
        if (x > MaxF) return MaxF[bit_width-1:0];
        if (x < MinF) return MinF[bit_width-1:0];
        return x[bit_width-1:0];
    endfunction

    // Multiply by W = cos - j*sin with twiddles in Q1.(word_length_tw-2).
    function automatic void rotate(input word_t xr, input word_t xi, input tw_t c, input tw_t s,
                                   output word_t yr, output word_t yi, output logic clip);
        full_t re_f;
        full_t im_f;
        re_f = rescale(full_t'(xr) * full_t'(c) + full_t'(xi) * full_t'(s), SH, HalfTw);
        im_f = rescale(full_t'(xi) * full_t'(c) - full_t'(xr) * full_t'(s), SH, HalfTw);
        yr   = clamp(re_f);
        yi   = clamp(im_f);
        clip = clips(re_f) || clips(im_f);
    endfunction

    function automatic void bfly(input word_t a, input word_t t, input logic sc,
                                 output word_t s, output word_t d, output logic clip);
        full_t sf;
        full_t df;
        sf = full_t'(a) + full_t'(t);
        df = full_t'(a) - full_t'(t);
        if (sc) begin
            sf = rescale(sf, 1, OneF);
            df = rescale(df, 1, OneF);
        end
        s    = clamp(sf);
        d    = clamp(df);
        clip = clips(sf) || clips(df);
    endfunction

    logic  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
    logic  ovf_q, ovf_d;
    s1_t   s1_q, s1_d;
    s2_t   s2_q, s2_d;
    s3_t   s3_q, s3_d;
    s4_t   s4_q, s4_d;
    logic  advance;
    logic  ovf_set;
    word_t t1_re, t1_im, t2_re, t2_im;
    word_t o1_re, o1_im, o2_re, o2_im;
    logic  clip_t1, clip_t2, clip_re, clip_im;

    always_comb begin
        advance = !v4_q || bus.out_ready;
        v1_d    = v1_q;
        v2_d    = v2_q;
        v3_d    = v3_q;
        v4_d    = v4_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        s3_d    = s3_q;
        s4_d    = s4_q;

        rotate(s1_q.b.re, s1_q.b.im, s1_q.cos1, s1_q.sin1, t1_re, t1_im, clip_t1);
        rotate(s2_q.t.re, s2_q.t.im, s2_q.cos2, s2_q.sin2, t2_re, t2_im, clip_t2);
        bfly(s3_q.a.re, s3_q.t.re, s3_q.scale, o1_re, o2_re, clip_re);
        bfly(s3_q.a.im, s3_q.t.im, s3_q.scale, o1_im, o2_im, clip_im);

        // Stages capture zero on bubbles so idle data never toggles or flags overflow.
        if (advance) begin
            v1_d = bus.in_valid;
            v2_d = v1_q;
            v3_d = v2_q;
            v4_d = v3_q;
            s1_d = '0;
            s2_d = '0;
            s3_d = '0;
            s4_d = '0;
            if (bus.in_valid) begin
                s1_d.mode  = bus.mode;
                s1_d.scale = bus.scale;
                s1_d.cos1  = bus.cos_data;
                s1_d.sin1  = bus.sin_data;
                s1_d.cos2  = bus.cos_data2;
                s1_d.sin2  = bus.sin_data2;
                s1_d.a     = {bus.Re_i1, bus.Im_i1};
                s1_d.b     = {bus.Re_i2, bus.Im_i2};
            end
            if (v1_q) begin
                s2_d.mode  = s1_q.mode;
                s2_d.scale = s1_q.scale;
                s2_d.cos2  = s1_q.cos2;
                s2_d.sin2  = s1_q.sin2;
                s2_d.a     = s1_q.a;
                s2_d.t     = {t1_re, t1_im};
            end
            if (v2_q) begin
                s3_d.scale = s2_q.scale;
                s3_d.a     = s2_q.a;
                s3_d.t     = s2_q.mode ? {t2_re, t2_im} : s2_q.t;
            end
            if (v3_q) begin
                s4_d.o1 = {o1_re, o1_im};
                s4_d.o2 = {o2_re, o2_im};
            end
        end

        ovf_set = advance && ((v1_q && clip_t1) || (v2_q && s2_q.mode && clip_t2) ||
                              (v3_q && (clip_re || clip_im)));
        ovf_d   = ovf_set ? 1'b1 : (bus.clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            v4_q  <= 1'b0;
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            s4_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
            v4_q  <= v4_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            s4_q  <= s4_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = v4_q;
    assign bus.Re_o1     = s4_q.o1.re;
    assign bus.Im_o1     = s4_q.o1.im;
    assign bus.Re_o2     = s4_q.o2.re;
    assign bus.Im_o2     = s4_q.o2.im;
    assign bus.ovf       = ovf_q;
endmodule

// File: doc/pipelined_modify_radix2.md
# pipelined_modify_radix2

Pipelined, parametrised successor to the combinational modified radix-2 butterfly. It applies one or two cascaded twiddle rotations to the lower input, then forms the sum and difference with the upper input. Additions over the combinational butterfly: registered stages, valid/ready flow control, rounding, per-sample scaling, saturation and a sticky overflow flag. It sits between the twiddle ROMs and the stage reorder buffers of the parallel FFT datapath.

## Interface
- bit_width, 16: width of every real/imag data word, in and out.
- word_length_tw, 8: twiddle width, signed Q1.(word_length_tw-2); +1.0 = 2^(word_length_tw-2).
- ROUND, 1: 0 = truncate (arithmetic shift); 1 = round half up (add half-LSB before the shift).
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts input; an input is accepted on an edge where in_valid && in_ready.
- mode  in  1  0 = single rotation (t = b·W1); 1 = cascaded rotation (t = b·W1·W2).
- scale  in  1  1 = halve both butterfly outputs.
- sin_data, cos_data, sin_data2, cos_data2  in  word_length_tw each  twiddles W1 and W2.
- Re_i1, Im_i1  in  bit_width each  upper input a.
- Re_i2, Im_i2  in  bit_width each  lower input b.
- out_ready  in  1  downstream accepts output.
- Re_o1, Im_o1, Re_o2, Im_o2  out  bit_width each  o1 = a + t, o2 = a − t.
- out_valid  out  1  outputs valid.
- ovf  out  1  sticky overflow/saturation flag.
- clr_ovf  in  1  clears ovf.

## Operation
- mode, scale, twiddles and data are all sampled together with in_valid and travel with the sample. Each sample uses its own mode and scale.
- Rotation by W = cos − j·sin:
  - Re = (Re·cos + Im·sin) >>> (word_length_tw−2).
  - Im = (Im·cos − Re·sin) >>> (word_length_tw−2).
  - Full-precision intermediate is bit_width+word_length_tw+1 bits.
  - Apply ROUND, then saturate to bit_width.
- The second rotation takes the saturated t1. In mode 0, t = t1; in mode 1, t = t2.
- Butterfly:
  - Sum and difference are computed at bit_width+1 bits.
  - If scale = 1, shift >>> 1 with ROUND applied.
  - Saturate to bit_width: clamp to +2^(bit_width−1)−1 / −2^(bit_width−1).
- ovf is set on an edge where any saturation clamps a value for a valid sample, whether in t1, t2 (mode 1 only) or any output.
- clr_ovf clears ovf. If set and clear occur on the same edge, set wins.
- Bubbles (invalid stages) never set ovf. Their data is don't-care but is held at zero.
- Pipeline stages:
  - S1 registers inputs.
  - S2 holds t1, with a delayed alongside.
  - S3 holds t2 (or t1 passed through), with a delayed alongside.
  - S4 is the output register.
- Flow control is a global stall:
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - When advance = 0, every stage, including its valid bit, holds.
  - Bubbles are not collapsed.

## Timing
- Reset (rst high at an edge):
  - All stage valid bits become 0; out_valid = 0.
  - Re_o1, Im_o1, Re_o2, Im_o2 = 0; ovf = 0.
  - in_ready reads 1 from the cycle after the reset edge.
  - rst dominates clr_ovf and any in-flight overflow.
- Reset mid-stream discards all in-flight samples; none appears afterwards.
- Latency: a sample accepted at edge N appears on the outputs after edge N+3, with out_valid = 1, provided no stall occurs. Every stall cycle adds one cycle.
- Throughput is one sample per cycle when out_ready is held high. Latency is identical for mode 0 and mode 1.
- While out_valid && !out_ready, outputs are stable and in_ready = 0. An input presented then is not accepted and must be held by the source.
- out_valid deasserts on the edge after a handshake only if S3 held a bubble.

## Test plan
- bit_width=16, word_length_tw=8, mode 0, W1 = (cos 64, sin 0), a = (1000, 0), b = (200, 0), scale 0 → o1 = (1200, 0), o2 = (800, 0) after edge N+3, ovf = 0.
- Mode 1, W1 = W2 = (cos 0, sin 64), a = (0, 0), b = (100, 0) → t1 = (0, −100), t2 = (−100, 0), o1 = (−100, 0), o2 = (100, 0). The same sample in mode 0 gives o1 = (0, −100).
- Saturation, W1 = 1.0:
  - a = b = (32000, 0), scale 0 → o1 = (32767, 0), o2 = (0, 0), ovf = 1 and stays 1.
  - clr_ovf pulse → ovf = 0.
  - Same input with scale 1 → o1 = (32000, 0), ovf stays 0.
- Rounding, W1 = (cos 32, sin 0), b = (3, 0), a = 0:
  - ROUND=1 → t = 2, o1 = (2, 0).
  - ROUND=0 → o1 = (1, 0).
- Backpressure: stream 8 back-to-back samples; drop out_ready for 3 cycles mid-stream → all 8 outputs appear in order with none lost or duplicated, outputs are held stable while stalled, and in_ready = 0 exactly during the stall.
- Reset mid-stream: assert rst with 3 samples in flight → out_valid = 0, all outputs = 0 and ovf = 0 after the reset edge, and no stale sample ever appears. A new sample accepted afterwards emerges 3 edges later.
